// File: rtl/det_matrix_loader.sv
// rtl/det_matrix_loader.sv - serial 4x4 matrix loader feeding the determinant stage
// Gathers 16 elements, holds them for DET_LATENCY cycles, then captures and presents the determinant.
module det_matrix_loader #(
  parameter int DATA_W      = 8,
  parameter int DET_LATENCY = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_data,
  output logic [16*DATA_W-1:0] mat_flat,
  input  logic [DATA_W-1:0]    det_result,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [DATA_W-1:0]    res_data,
  output logic                 busy
);

  typedef enum logic [1:0] {S_LOAD, S_WAIT, S_DONE} state_t;

  localparam logic [3:0] LP_LAST_WAIT = 4'(DET_LATENCY - 1);

  state_t            r_state;
  state_t            w_next_state;
  logic [3:0]        r_idx;
  logic [3:0]        r_wait_cnt;
  logic [DATA_W-1:0] r_elem [16];
  logic              r_res_valid;
  logic [DATA_W-1:0] r_res_data;

  logic w_in_fire;
  logic w_res_fire;
  logic w_wait_done;

  assign in_ready    = (r_state == S_LOAD);
  assign busy        = (r_state != S_LOAD);
  assign res_valid   = r_res_valid;
  assign res_data    = r_res_data;
  assign w_in_fire   = in_valid && in_ready;
  assign w_res_fire  = r_res_valid && res_ready;
  assign w_wait_done = (r_wait_cnt == LP_LAST_WAIT);

  for (genvar k = 0; k < 16; k++) begin : g_flat
    assign mat_flat[DATA_W*k +: DATA_W] = r_elem[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (clear) begin
      w_next_state = S_LOAD;
    end else begin
      case (r_state)
        S_LOAD: if (w_in_fire && (r_idx == 4'd15)) w_next_state = S_WAIT;
        S_WAIT: if (w_wait_done) w_next_state = S_DONE;
        S_DONE: if (w_res_fire) w_next_state = S_LOAD;
        default: w_next_state = S_LOAD;
      endcase
    end
  end

  // clear drops any same-cycle transfer and wipes the matrix, but res_data survives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx       <= '0;
      r_wait_cnt  <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      for (int k = 0; k < 16; k++) r_elem[k] <= '0;
    end else if (clear) begin
      r_idx       <= '0;
      r_wait_cnt  <= '0;
      r_res_valid <= 1'b0;
      for (int k = 0; k < 16; k++) r_elem[k] <= '0;
    end else begin
      case (r_state)
        S_LOAD: begin
          r_wait_cnt <= '0;
          if (w_in_fire) begin
            r_elem[r_idx] <= in_data;
            r_idx         <= r_idx + 4'd1;
          end
        end
        S_WAIT: begin
          r_wait_cnt <= r_wait_cnt + 4'd1;
          if (w_wait_done) begin
            r_res_data  <= det_result;
            r_res_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (w_res_fire) begin
            r_res_valid <= 1'b0;
            r_idx       <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_det_matrix_loader.sv
// tb/tb_det_matrix_loader.sv - self-checking bench for det_matrix_loader
// Expected determinants are queued when a load is driven and popped at the result handshake.
module tb_det_matrix_loader;

  localparam int DW  = 8;
  localparam int LAT = 3;

  logic            clk;
  logic            rst_n;
  logic            clear;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_data;
  logic [16*DW-1:0] mat_flat;
  logic [DW-1:0]   det_result;
  logic            res_valid;
  logic            res_ready;
  logic [DW-1:0]   res_data;
  logic            busy;

  int errors = 0;
  int checks = 0;

  logic [7:0]   elems [16];
  logic [127:0] exp_flat;
  logic [7:0]   exp_q [$];

  det_matrix_loader #(.DATA_W(DW), .DET_LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mat_flat(mat_flat), .det_result(det_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, actual time=%0t required below 500000", $time);
    $fatal(1);
  end

  task automatic build_flat();
    for (int k = 0; k < 16; k++) exp_flat[8*k +: 8] = elems[k];
  endtask

  task automatic load_matrix(input int max_gap);
    for (int k = 0; k < 16; k++) begin
      int n;
      n = 0;
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) begin @(posedge clk); #1; end
      in_valid = 1'b1;
      in_data  = elems[k];
      while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
      checks++;
      if (!in_ready) begin
        errors++;
        $display("FAIL load_ready_timeout: element %0d in_ready=%b required 1", k, in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic collect_result(input string name);
    int n;
    logic [7:0] e;
    n = 0;
    res_ready = 1'b1;
    while (!res_valid && n < 20) begin @(posedge clk); #1; n++; end
    checks++;
    if (!res_valid) begin
      errors++;
      $display("FAIL %s_timeout: res_valid=%b required 1", name, res_valid);
    end else if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s_unexpected: res_data=%h with empty scoreboard, required no result", name, res_data);
    end else begin
      e = exp_q.pop_front();
      if (res_data !== e) begin
        errors++;
        $display("FAIL %s_data: res_data=%h required %h", name, res_data, e);
      end
    end
    @(posedge clk); #1;
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_release: res_valid=%b in_ready=%b busy=%b required 0 1 0", name, res_valid, in_ready, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0;
    det_result = '0; res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0 || res_data !== 8'h00 || mat_flat !== '0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b busy=%b res_valid=%b res_data=%h mat_flat=%h required 1 0 0 00 0",
               in_ready, busy, res_valid, res_data, mat_flat);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 7; k++) begin
      in_valid = 1'b1; in_data = 8'h10 + 8'(k);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++;
    if (mat_flat[55:0] !== 56'h16_15_14_13_12_11_10) begin
      errors++;
      $display("FAIL partial_load: mat_flat[55:0]=%h required 16151413121110", mat_flat[55:0]);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || res_valid !== 1'b0 || mat_flat !== '0) begin
      errors++;
      $display("FAIL async_reset: in_ready=%b res_valid=%b mat_flat=%h required 1 0 0", in_ready, res_valid, mat_flat);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    in_valid = 1'b1; in_data = 8'h5A;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (mat_flat !== 128'h5A) begin
      errors++;
      $display("FAIL reset_idx: mat_flat=%h required 5a in bits [7:0] only", mat_flat);
    end
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic test_load_compute();
    elems = '{8'd1, 8'd2, 8'd1, 8'd2, 8'd2, 8'd1, 8'd3, 8'd2,
              8'd3, 8'd2, 8'd2, 8'd1, 8'd1, 8'd2, 8'd3, 8'd1};
    build_flat();
    det_result = 8'h2A;
    exp_q.push_back(8'h2A);
    load_matrix(0);
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL post_t0_ctrl: in_ready=%b busy=%b required 0 1", in_ready, busy);
    end
    checks++;
    if (mat_flat[7:0] !== 8'd1 || mat_flat[15:8] !== 8'd2 || mat_flat[71:64] !== 8'd3 || mat_flat[127:120] !== 8'd1) begin
      errors++;
      $display("FAIL elem_bytes: a=%h b=%h i=%h p=%h required 01 02 03 01",
               mat_flat[7:0], mat_flat[15:8], mat_flat[71:64], mat_flat[127:120]);
    end
    checks++;
    if (mat_flat !== exp_flat) begin
      errors++;
      $display("FAIL mat_flat_b2b: mat_flat=%h required %h", mat_flat, exp_flat);
    end
    checks++;
    if (res_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_t0: res_valid=%b after edge T0 required 0", res_valid);
    end
    for (int e = 1; e <= LAT; e++) begin
      @(posedge clk); #1;
      checks++;
      if (res_valid !== (e == LAT)) begin
        errors++;
        $display("FAIL latency_edge%0d: res_valid=%b required %b", e, res_valid, (e == LAT));
      end
    end
  endtask

  task automatic test_hold();
    res_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; in_data = 8'hFF;
      @(posedge clk); #1;
      checks++;
      if (res_valid !== 1'b1 || res_data !== 8'h2A || in_ready !== 1'b0 || mat_flat !== exp_flat) begin
        errors++;
        $display("FAIL hold_cycle%0d: res_valid=%b res_data=%h in_ready=%b mat_flat=%h required 1 2a 0 %h",
                 c, res_valid, res_data, in_ready, mat_flat, exp_flat);
      end
    end
    in_valid = 1'b0;
    collect_result("hold");
  endtask

  task automatic test_gaps();
    int edges;
    edges = 0;
    det_result = 8'h81;
    exp_q.push_back(8'h81);
    load_matrix(3);
    checks++;
    if (mat_flat !== exp_flat || busy !== 1'b1) begin
      errors++;
      $display("FAIL gaps_flat: mat_flat=%h busy=%b required %h 1", mat_flat, busy, exp_flat);
    end
    while (!res_valid && edges < 20) begin @(posedge clk); #1; edges++; end
    checks++;
    if (edges !== LAT) begin
      errors++;
      $display("FAIL gaps_latency: res_valid after %0d edges past T0 required %0d", edges, LAT);
    end
    collect_result("gaps");
  endtask

  task automatic test_clear();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 16; k++) elems[k] = 8'(3 * k + 1);
    det_result = 8'h55;
    load_matrix(0);
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || mat_flat !== '0 || res_valid !== 1'b0 || res_data !== 8'h81) begin
      errors++;
      $display("FAIL clear_wait: in_ready=%b busy=%b mat_flat=%h res_valid=%b res_data=%h required 1 0 0 0 81",
               in_ready, busy, mat_flat, res_valid, res_data);
    end
    repeat (6) begin
      @(posedge clk); #1;
      if (res_valid) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL clear_abort: res_valid=1 seen for aborted matrix required 0");
    end
    clear = 1'b1; in_valid = 1'b1; in_data = 8'h77;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    checks++;
    if (mat_flat !== '0) begin
      errors++;
      $display("FAIL clear_drop: mat_flat=%h required 0", mat_flat);
    end
    for (int k = 0; k < 16; k++) elems[k] = 8'(8'hF0 - 8'(k * 7));
    build_flat();
    det_result = 8'h3C;
    exp_q.push_back(8'h3C);
    load_matrix(2);
    checks++;
    if (mat_flat !== exp_flat) begin
      errors++;
      $display("FAIL reload_flat: mat_flat=%h required %h", mat_flat, exp_flat);
    end
    collect_result("reload");
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d results outstanding required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_load_compute();
    test_hold();
    elems = '{8'd1, 8'd2, 8'd1, 8'd2, 8'd2, 8'd1, 8'd3, 8'd2,
              8'd3, 8'd2, 8'd2, 8'd1, 8'd1, 8'd2, 8'd3, 8'd1};
    build_flat();
    test_gaps();
    test_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
